// File: rtl/block_controller.sv
// block_controller: Breakout game-level sequencer.
// Gathers per-block hit/alive/bottom flags, arbitrates simultaneous hits down
// to a single winner, pulses a kill to it, requests ball bounces, keeps a
// saturating score and runs the IDLE/PLAY/WON/LOST game state.
//
// Ports:
//   clock, reset       clock; asynchronous active-low reset
//   start              level, starts/resumes play from IDLE
//   hit_v/hit_ud/hit_lr per-block hit flag, top/bottom face, left/right face
//   exist_v            per-block alive flag
//   endgame_v          per-block "reached bottom" flag
//   hit_lava           ball fell below the paddle
//   kill               one-hot one-cycle clear pulse to the winning block
//   grant_idx          index of the last granted block
//   bounce_v/bounce_h  one-cycle ball direction inversion requests
//   score              accumulated points (saturating)
//   game_state         0 IDLE, 1 PLAY, 2 WON, 3 LOST
//   endgame            high while game_state is LOST
//
// Optional feature: define BLOCK_CTRL_RR_EN for round-robin arbitration
// (default is fixed lowest-index priority).
module block_controller #(
    parameter int unsigned N_BLOCKS = 8,
    parameter int unsigned HOLDOFF  = 4,
    parameter int unsigned SCORE_W  = 10,
    parameter int unsigned POINTS   = 1
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [N_BLOCKS-1:0]                          hit_v,
    input  logic [N_BLOCKS-1:0]                          hit_ud,
    input  logic [N_BLOCKS-1:0]                          hit_lr,
    input  logic [N_BLOCKS-1:0]                          exist_v,
    input  logic [N_BLOCKS-1:0]                          endgame_v,
    input  logic                                         hit_lava,
    output logic [N_BLOCKS-1:0]                          kill,
    output logic [((N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1)-1:0] grant_idx,
    output logic                                         bounce_v,
    output logic                                         bounce_h,
    output logic [SCORE_W-1:0]                           score,
    output logic [1:0]                                   game_state,
    output logic                                         endgame
);

    localparam int unsigned IDX_W = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
    localparam int unsigned CNT_W = $clog2(HOLDOFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_HOLD,
        S_WON,
        S_LOST
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_BLOCKS-1:0]  kill_q, kill_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 bv_q, bv_d;
    logic                 bh_q, bh_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [1:0]           gs_q, gs_d;
    logic                 eg_q, eg_d;

    logic [N_BLOCKS-1:0]  hv;
    logic [N_BLOCKS-1:0]  ev;
    logic [IDX_W-1:0]     win_idx;
    logic [SCORE_W:0]     score_sum;

    // Only live blocks may hit or end the game
    assign hv = hit_v & exist_v;
    assign ev = endgame_v & exist_v;

    // Extra carry bit detects overflow for saturation
    assign score_sum = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(SCORE_W'(POINTS));

`ifdef BLOCK_CTRL_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Round-robin: scan from ptr+1 upward with wrap; the first set bit wins
    always_comb begin
        win_idx = '0;
        for (int k = int'(N_BLOCKS) - 1; k >= 0; k--) begin
            if (hv[(int'(ptr_q) + 1 + k) % int'(N_BLOCKS)]) begin
                win_idx = IDX_W'((int'(ptr_q) + 1 + k) % int'(N_BLOCKS));
            end
        end
    end
`else
    // Fixed priority: lowest set index wins
    always_comb begin
        win_idx = '0;
        for (int k = int'(N_BLOCKS) - 1; k >= 0; k--) begin
            if (hv[k]) begin
                win_idx = IDX_W'(k);
            end
        end
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = '0;
        grant_d = grant_q;
        bv_d    = 1'b0;
        bh_d    = 1'b0;
        score_d = score_q;
`ifdef BLOCK_CTRL_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARM;
            end
            S_ARM: begin
                if (|ev) begin
                    state_d = S_LOST;
                end else if (hit_lava) begin
                    state_d = S_IDLE;
                end else if (|hv) begin
                    kill_d  = N_BLOCKS'(1) << win_idx;
                    grant_d = win_idx;
                    bv_d    = hit_ud[win_idx];
                    bh_d    = hit_lr[win_idx];
                    score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    cnt_d   = CNT_W'(HOLDOFF - 1);
`ifdef BLOCK_CTRL_RR_EN
                    ptr_d   = win_idx;
`endif
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Hits are ignored; the counter reaching zero ends the holdoff
                if (|ev) begin
                    state_d = S_LOST;
                end else if (hit_lava) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = (exist_v == '0) ? S_WON : S_ARM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WON:   state_d = S_WON;
            S_LOST:  state_d = S_LOST;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_ARM, S_HOLD: gs_d = 2'd1;
            S_WON:         gs_d = 2'd2;
            S_LOST:        gs_d = 2'd3;
            default:       gs_d = 2'd0;
        endcase
        eg_d = (state_d == S_LOST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kill_q  <= '0;
            grant_q <= '0;
            bv_q    <= 1'b0;
            bh_q    <= 1'b0;
            score_q <= '0;
            gs_q    <= 2'd0;
            eg_q    <= 1'b0;
`ifdef BLOCK_CTRL_RR_EN
            // N_BLOCKS-1 makes the first search start at index 0
            ptr_q   <= IDX_W'(N_BLOCKS - 1);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            grant_q <= grant_d;
            bv_q    <= bv_d;
            bh_q    <= bh_d;
            score_q <= score_d;
            gs_q    <= gs_d;
            eg_q    <= eg_d;
`ifdef BLOCK_CTRL_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign kill       = kill_q;
    assign grant_idx  = grant_q;
    assign bounce_v   = bv_q;
    assign bounce_h   = bh_q;
    assign score      = score_q;
    assign game_state = gs_q;
    assign endgame    = eg_q;

endmodule

// File: tb/tb_block_controller.sv
// Directed testbench for block_controller: a default instance plus a
// SCORE_W=2 instance sharing the same stimulus for the saturation case.
module tb_block_controller;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] hit_v, hit_ud, hit_lr, exist_v, endgame_v;
    logic       hit_lava;

    logic [7:0] kill;
    logic [2:0] grant_idx;
    logic       bounce_v, bounce_h;
    logic [9:0] score;
    logic [1:0] game_state;
    logic       endgame;

    logic [7:0] s_kill;
    logic [2:0] s_grant_idx;
    logic       s_bounce_v, s_bounce_h;
    logic [1:0] s_score;
    logic [1:0] s_game_state;
    logic       s_endgame;

    int n_checks = 0;
    int n_errors = 0;
    int kills;
    int exp_g1, exp_g2;

    block_controller u_dut (
        .clock(clock), .reset(reset), .start(start),
        .hit_v(hit_v), .hit_ud(hit_ud), .hit_lr(hit_lr),
        .exist_v(exist_v), .endgame_v(endgame_v), .hit_lava(hit_lava),
        .kill(kill), .grant_idx(grant_idx), .bounce_v(bounce_v),
        .bounce_h(bounce_h), .score(score), .game_state(game_state),
        .endgame(endgame)
    );

    block_controller #(.SCORE_W(2)) u_sat (
        .clock(clock), .reset(reset), .start(start),
        .hit_v(hit_v), .hit_ud(hit_ud), .hit_lr(hit_lr),
        .exist_v(exist_v), .endgame_v(endgame_v), .hit_lava(hit_lava),
        .kill(s_kill), .grant_idx(s_grant_idx), .bounce_v(s_bounce_v),
        .bounce_h(s_bounce_h), .score(s_score), .game_state(s_game_state),
        .endgame(s_endgame)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_in();
        hit_v = '0; hit_ud = '0; hit_lr = '0; endgame_v = '0; hit_lava = 1'b0;
    endtask

    initial begin
`ifdef BLOCK_CTRL_RR_EN
        // Pointer sits at 2 after the single-hit test, so 0x12 grants 4 then 1
        exp_g1 = 4; exp_g2 = 1;
`else
        exp_g1 = 1; exp_g2 = 1;
`endif
        reset = 1'b0; start = 1'b0; exist_v = '0;
        clear_in();
        #12;
        check("rst_kill", 32'(kill), 32'h0);
        check("rst_score", 32'(score), 32'h0);
        check("rst_state", 32'(game_state), 32'h0);
        check("rst_endgame", 32'(endgame), 32'h0);
        reset = 1'b1;

        // Start, then single hit on block 2 (top face)
        start = 1'b1;
        step();
        check("start_play", 32'(game_state), 32'h1);
        start = 1'b0;
        hit_v = 8'h04; exist_v = 8'h04; hit_ud = 8'h04;
        step();
        check("single_kill", 32'(kill), 32'h04);
        check("single_grant", 32'(grant_idx), 32'h2);
        check("single_bv", 32'(bounce_v), 32'h1);
        check("single_bh", 32'(bounce_h), 32'h0);
        check("single_score", 32'(score), 32'h1);
        clear_in();
        step();
        check("kill_pulse", 32'(kill), 32'h0);
        check("bv_pulse", 32'(bounce_v), 32'h0);
        step(3);

        // Simultaneous hits on blocks 1 and 4, held through the holdoff
        hit_v = 8'h12; exist_v = 8'h12; hit_lr = 8'h12;
        step();
        check("simul_g1", 32'(grant_idx), 32'(exp_g1));
        check("simul_bh", 32'(bounce_h), 32'h1);
        check("simul_bv", 32'(bounce_v), 32'h0);
        step();
        check("hold_ignores", 32'(kill), 32'h0);
        step(4);
        check("simul_g2", 32'(grant_idx), 32'(exp_g2));
        check("simul_score", 32'(score), 32'h3);
        check("sat_exact", 32'(s_score), 32'h3);
        clear_in();
        step(4);

        // Holdoff: one block held for 10 ARM-relative cycles, corner hit
        hit_v = 8'h01; exist_v = 8'h01; hit_ud = 8'h01; hit_lr = 8'h01;
        kills = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (kill != '0) kills++;
            if (i == 0) check("corner_bounce", 32'({bounce_v, bounce_h}), 32'h3);
            if (i == 5) check("regrant_t5", 32'(kill), 32'h01);
        end
        check("holdoff_kills", 32'(kills), 32'h2);
        check("holdoff_score", 32'(score), 32'h5);
        check("sat_hold", 32'(s_score), 32'h3);
        clear_in();

        // Lava during HOLD returns to IDLE keeping the score
        hit_v = 8'h01;
        step();
        check("lava_grant_score", 32'(score), 32'h6);
        hit_v = '0; hit_lava = 1'b1;
        step();
        check("lava_idle", 32'(game_state), 32'h0);
        check("lava_kill", 32'(kill), 32'h0);
        hit_lava = 1'b0;
        step();
        check("idle_wait", 32'(game_state), 32'h0);
        check("lava_keep_score", 32'(score), 32'h6);
        start = 1'b1;
        step();
        check("resume_play", 32'(game_state), 32'h1);
        start = 1'b0;

        // Dead block reaching bottom is masked
        endgame_v = 8'h80;
        step();
        check("ev_masked", 32'(game_state), 32'h1);
        endgame_v = '0;

        // Kill the last live block; WON after the holdoff
        hit_v = 8'h01;
        step();
        check("last_kill", 32'(kill), 32'h01);
        check("last_score", 32'(score), 32'h7);
        hit_v = '0; exist_v = '0;
        step(3);
        check("won_not_yet", 32'(game_state), 32'h1);
        step();
        check("won", 32'(game_state), 32'h2);
        start = 1'b1;
        step(2);
        check("won_sticky", 32'(game_state), 32'h2);
        start = 1'b0;

        // Asynchronous reset mid-HOLD, checked between clock edges
        reset = 1'b0; #2; reset = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        hit_v = 8'h02; exist_v = 8'h02; hit_ud = 8'h02;
        step();
        check("pre_rst_kill", 32'(kill), 32'h02);
        #2 reset = 1'b0;
        #1;
        check("async_kill", 32'(kill), 32'h0);
        check("async_score", 32'(score), 32'h0);
        check("async_grant", 32'(grant_idx), 32'h0);
        check("async_bv", 32'(bounce_v), 32'h0);
        check("async_state", 32'(game_state), 32'h0);
        #1 reset = 1'b1;
        clear_in();

        // ev beats lava beats hit in one ARM cycle
        start = 1'b1;
        step();
        start = 1'b0;
        hit_v = 8'h01; exist_v = 8'h03; endgame_v = 8'h02; hit_lava = 1'b1;
        step();
        check("prio_state", 32'(game_state), 32'h3);
        check("prio_endgame", 32'(endgame), 32'h1);
        check("prio_kill", 32'(kill), 32'h0);
        check("prio_score", 32'(score), 32'h0);
        clear_in();
        for (int i = 0; i < 3; i++) begin
            start = ~start;
            step();
        end
        check("lost_sticky", 32'(game_state), 32'h3);
        check("lost_endgame", 32'(endgame), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
